scan_beta_mem_param: RTL and testbench
======================================

Name: scan_beta_mem_param

Overview:
- Parametrised partial-sum (beta) storage for the SCAN polar decoder, one bank per decoding layer 1..LMAX.
- Receives 2P beta values per cycle from the processing-element array and returns P values per cycle for the next F/G computation.
- Generalises the fixed 1024/64 beta RAM to arbitrary N, P and Q.
- Adds write-first read forwarding, a single-cycle layer clear, a read-valid strobe and out-of-range error flags.

Parameters:
- P, 64, number of PE lanes; read word = up to P entries, write word = up to 2P entries.
- Q, 6, bits per beta entry.
- LMAX, 9, highest stored layer; layer l holds 2^l entries (layer 9 = 512 entries for N=1024).
- LW, $clog2(LMAX+1), width of layer-select ports.
- AW, LMAX, width of address ports.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- w_en  in  1  write strobe.
- w_layer  in  LW  target layer of write.
- w_addr  in  AW  write word address, in units of W(l).
- w_data  in  2*P*Q  write lanes; lane k = bits [k*Q +: Q].
- r_en  in  1  read strobe.
- r_layer  in  LW  source layer of read.
- r_addr  in  AW  read word address, in units of R(l).
- clr_en  in  1  clear-layer strobe.
- clr_layer  in  LW  layer to zero.
- r_data  out  P*Q  read lanes, registered.
- r_valid  out  1  r_data holds a valid read.
- r_err  out  1  pulse: read request rejected.
- w_err  out  1  pulse: write request rejected.

Behaviour:
- Word sizes: W(l)=min(2P, 2^l) entries per write word; R(l)=min(P, 2^l) entries per read word. Word counts: 2^l/W(l) (write), 2^l/R(l) (read).
- Write: when w_en=1 and the request is legal, lane k for k<W(l) is stored at entry w_addr*W(l)+k of layer w_layer, effective at the next clock. Lanes k>=W(l) are ignored.
- Read: when r_en=1 and the request is legal, the next cycle has r_data lane k = entry r_addr*R(l)+k for k<R(l), upper lanes = 0, and r_valid=1. Latency is exactly 1 cycle.
- No read in a cycle (r_en=0): the next cycle has r_data=0 and r_valid=0.
- Illegal request: layer=0, layer>LMAX, or address >= word count for that layer.
  - The request is ignored.
  - The matching *_err pulses high for 1 cycle, registered in the same timing as r_valid.
  - An illegal read also gives r_data=0 and r_valid=0.
- Read/write collision (write-first): legal read and write in the same cycle, same layer, with overlapping entries.
  - Overlapping lanes return the new w_data values.
  - Non-overlapping lanes return the stored values.
- Clear: clr_en=1 with a legal clr_layer zeroes every entry of that layer at the next clock. An illegal clr_layer is silently ignored.
- Clear + write, same layer, same cycle: the written entries take w_data; all other entries become 0.
- Clear + read, same layer, same cycle: the read returns pre-clear stored data, with write forwarding still applied.
- Different layers are independent; write, read and clear may target three different layers in one cycle.
- Reset: every entry, r_data, r_valid, r_err and w_err go to 0 on the clock where rst=1. rst overrides any simultaneous request. A read issued in the cycle rst is asserted produces no r_valid.
- Storage: flip-flop arrays, one per layer, generated by loop over l. Each array is 2^l*Q bits and is indexed by an entry index computed at full width (no truncation).

Test Plan (bench P=4, Q=6, LMAX=5):
- Reset then read layer 3 addr 0 -> r_valid=1 one cycle later, r_data=0.
- Write layer 5 addr 1 with lanes 0..7 = 1..8; next cycle read layer 5 addr 2 -> lanes 0..3 = 1,2,3,4; addr 3 -> 5,6,7,8.
- Write layer 1 addr 0 lanes = 9,10,11,...; read layer 1 addr 0 -> lanes 0,1 = 9,10; lanes 2,3 = 0.
- Same cycle: write layer 4 addr 0 lanes 0..7 = 20..27 and read layer 4 addr 1 -> next cycle r_data = 24,25,26,27 (forwarded).
- Fill layer 2 with 1..4, then assert clr_en layer 2 together with a write to layer 2 addr 0 of 7,7,7,7 -> later read returns 7,7,7,7; a separately cleared layer reads all 0.
- Read layer 6 or layer 3 addr 2 -> r_err pulses 1 cycle, r_valid=0, r_data=0. Write layer 0 -> w_err pulses, no storage change. Reset asserted mid-read -> r_valid=0 next cycle.

Source files
------------

// File: rtl/scan_beta_mem_param.sv
// Partial-sum (beta) storage for a SCAN polar decoder: one flip-flop bank per layer 1..LMAX.
// Write-first forwarding, single-cycle layer clear, registered read with valid and error strobes.
module scan_beta_mem_param #(
  parameter int P    = 64,
  parameter int Q    = 6,
  parameter int LMAX = 9,
  parameter int LW   = $clog2(LMAX + 1),
  parameter int AW   = LMAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic [LW-1:0]     w_layer,
  input  logic [AW-1:0]     w_addr,
  input  logic [2*P*Q-1:0]  w_data,
  input  logic              r_en,
  input  logic [LW-1:0]     r_layer,
  input  logic [AW-1:0]     r_addr,
  input  logic              clr_en,
  input  logic [LW-1:0]     clr_layer,
  output logic [P*Q-1:0]    r_data,
  output logic              r_valid,
  output logic              r_err,
  output logic              w_err
);

  logic [LMAX:0]  w_wr_hit;
  logic [LMAX:0]  w_rd_hit;
  logic [P*Q-1:0] w_rd_word [LMAX+1];
  logic [P*Q-1:0] w_rd_mux;
  logic           w_r_legal;
  logic           w_w_legal;

  logic [P*Q-1:0] r_rdata;
  logic           r_rvalid;
  logic           r_rerr;
  logic           r_werr;

  // Layer 0 does not exist; its slot only keeps the hit vectors uniformly indexed.
  assign w_wr_hit[0]  = 1'b0;
  assign w_rd_hit[0]  = 1'b0;
  assign w_rd_word[0] = '0;

  for (genvar l = 1; l <= LMAX; l++) begin : g_layer
    localparam int N    = 2 ** l;
    localparam int WL   = (2 * P < N) ? 2 * P : N;
    localparam int RL   = (P < N) ? P : N;
    localparam int WCNT = N / WL;
    localparam int RCNT = N / RL;

    logic [Q-1:0]   r_mem [N];
    logic [Q-1:0]   w_fwd [N];
    logic [P*Q-1:0] w_rd;
    logic           w_clr;

    // Address bounds compared one bit wider so a word count of 2^AW still fits.
    assign w_wr_hit[l] = w_en && (w_layer == LW'(l)) && ({1'b0, w_addr} < (AW + 1)'(WCNT));
    assign w_rd_hit[l] = r_en && (r_layer == LW'(l)) && ({1'b0, r_addr} < (AW + 1)'(RCNT));
    assign w_clr       = clr_en && (clr_layer == LW'(l));

    // Stored entry with the same-cycle write applied on top (pre-clear view).
    always_comb begin
      for (int e = 0; e < N; e++) begin
        if (w_wr_hit[l] && (w_addr == AW'(e / WL))) begin
          w_fwd[e] = w_data[(e % WL) * Q +: Q];
        end else begin
          w_fwd[e] = r_mem[e];
        end
      end
    end

    // Select the addressed read word; lanes at and above RL stay zero.
    always_comb begin
      w_rd = '0;
      for (int rw = 0; rw < RCNT; rw++) begin
        for (int k = 0; k < RL; k++) begin
          w_rd[k * Q +: Q] = w_rd[k * Q +: Q] | ((r_addr == AW'(rw)) ? w_fwd[rw * RL + k] : '0);
        end
      end
    end

    assign w_rd_word[l] = w_rd;

    // Entry update: reset, then write, then clear; a write beats a clear on the same entry.
    always_ff @(posedge clk) begin
      for (int e = 0; e < N; e++) begin
        if (rst) begin
          r_mem[e] <= '0;
        end else if (w_wr_hit[l] && (w_addr == AW'(e / WL))) begin
          r_mem[e] <= w_data[(e % WL) * Q +: Q];
        end else if (w_clr) begin
          r_mem[e] <= '0;
        end else begin
          r_mem[e] <= r_mem[e];
        end
      end
    end
  end

  // At most one layer can hit, so OR-ing the per-layer words forms the read mux.
  always_comb begin
    w_rd_mux = '0;
    for (int l = 1; l <= LMAX; l++) begin
      w_rd_mux = w_rd_mux | (w_rd_hit[l] ? w_rd_word[l] : '0);
    end
    w_r_legal = |w_rd_hit;
    w_w_legal = |w_wr_hit;
  end

  // Registered read port and error strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_rerr   <= 1'b0;
      r_werr   <= 1'b0;
    end else begin
      r_rdata  <= w_r_legal ? w_rd_mux : '0;
      r_rvalid <= w_r_legal;
      r_rerr   <= r_en && !w_r_legal;
      r_werr   <= w_en && !w_w_legal;
    end
  end

  assign r_data  = r_rdata;
  assign r_valid = r_rvalid;
  assign r_err   = r_rerr;
  assign w_err   = r_werr;

endmodule

// File: tb/tb_scan_beta_mem_param.sv
// Scoreboard bench for scan_beta_mem_param with P=4, Q=6, LMAX=5.
module tb_scan_beta_mem_param;

  localparam int P    = 4;
  localparam int Q    = 6;
  localparam int LMAX = 5;
  localparam int LW   = 3;
  localparam int AW   = 5;

  logic              clk;
  logic              rst;
  logic              w_en;
  logic [LW-1:0]     w_layer;
  logic [AW-1:0]     w_addr;
  logic [2*P*Q-1:0]  w_data;
  logic              r_en;
  logic [LW-1:0]     r_layer;
  logic [AW-1:0]     r_addr;
  logic              clr_en;
  logic [LW-1:0]     clr_layer;
  logic [P*Q-1:0]    r_data;
  logic              r_valid;
  logic              r_err;
  logic              w_err;

  typedef struct {
    logic [P*Q-1:0] data;
    logic           valid;
    logic           rerr;
    logic           werr;
  } exp_t;

  exp_t       sb[$];
  logic [Q-1:0] mdl [0:7][0:31];
  int         n_vec = 0;
  int         n_bad = 0;

  scan_beta_mem_param #(.P(P), .Q(Q), .LMAX(LMAX), .LW(LW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .w_en(w_en), .w_layer(w_layer), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_layer(r_layer), .r_addr(r_addr),
    .clr_en(clr_en), .clr_layer(clr_layer),
    .r_data(r_data), .r_valid(r_valid), .r_err(r_err), .w_err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wsize(int l, int cap);
    return ((1 << l) < cap) ? (1 << l) : cap;
  endfunction

  function automatic logic [2*P*Q-1:0] lanes(int base, int step);
    logic [2*P*Q-1:0] v;
    v = '0;
    for (int k = 0; k < 2 * P; k++) v[k*Q +: Q] = 6'(base + k * step);
    return v;
  endfunction

  // Model the request, push the expected registered outputs, then clock it in.
  task automatic apply(input logic we, input int wl, input int wa, input logic [2*P*Q-1:0] wd,
                       input logic re, input int rl, input int ra,
                       input logic ce, input int cl, input logic rs);
    exp_t e;
    logic r_ok, w_ok;
    logic [Q-1:0] v;
    int rr, ww, idx;
    e.data = '0; e.valid = 1'b0; e.rerr = 1'b0; e.werr = 1'b0;
    if (rs) begin
      for (int l = 0; l < 8; l++) for (int x = 0; x < 32; x++) mdl[l][x] = '0;
    end else begin
      r_ok = re && rl >= 1 && rl <= LMAX && ra < (1 << rl) / wsize(rl, P);
      w_ok = we && wl >= 1 && wl <= LMAX && wa < (1 << wl) / wsize(wl, 2 * P);
      if (r_ok) begin
        rr = wsize(rl, P);
        ww = wsize(rl, 2 * P);
        for (int k = 0; k < rr; k++) begin
          idx = ra * rr + k;
          v = mdl[rl][idx];
          if (w_ok && wl == rl && idx / ww == wa) v = wd[(idx % ww) * Q +: Q];
          e.data[k*Q +: Q] = v;
        end
      end
      e.valid = r_ok;
      e.rerr  = re && !r_ok;
      e.werr  = we && !w_ok;
      if (ce && cl >= 1 && cl <= LMAX)
        for (int x = 0; x < (1 << cl); x++) mdl[cl][x] = '0;
      if (w_ok) begin
        ww = wsize(wl, 2 * P);
        for (int k = 0; k < ww; k++) mdl[wl][wa * ww + k] = wd[k*Q +: Q];
      end
    end
    sb.push_back(e);
    w_en = we; w_layer = LW'(wl); w_addr = AW'(wa); w_data = wd;
    r_en = re; r_layer = LW'(rl); r_addr = AW'(ra);
    clr_en = ce; clr_layer = LW'(cl); rst = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      case (i)
        0:       apply(1'b0, 0, 0, '0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        default: apply(1'b0, 0, 0, '0, 1'b1, 3, 0, 1'b0, 0, 1'b0);
      endcase
      e = sb.pop_front();
      n_vec++;
      if (r_data !== e.data || r_valid !== e.valid || r_err !== e.rerr || w_err !== e.werr) begin
        n_bad++;
        $display("FAIL reset[%0d]: got d=%h v=%b re=%b we=%b, want d=%h v=%b re=%b we=%b",
                 i, r_data, r_valid, r_err, w_err, e.data, e.valid, e.rerr, e.werr);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       apply(1'b1, 5, 1, lanes(1, 1), 1'b0, 0, 0, 1'b0, 0, 1'b0);
        1:       apply(1'b0, 0, 0, '0, 1'b1, 5, 2, 1'b0, 0, 1'b0);
        2:       apply(1'b0, 0, 0, '0, 1'b1, 5, 3, 1'b0, 0, 1'b0);
        3:       apply(1'b1, 1, 0, lanes(9, 1), 1'b0, 0, 0, 1'b0, 0, 1'b0);
        4:       apply(1'b0, 0, 0, '0, 1'b1, 1, 0, 1'b0, 0, 1'b0);
        default: apply(1'b0, 0, 0, '0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
      endcase
      e = sb.pop_front();
      n_vec++;
      if (r_data !== e.data || r_valid !== e.valid || r_err !== e.rerr || w_err !== e.werr) begin
        n_bad++;
        $display("FAIL write_read[%0d]: got d=%h v=%b re=%b we=%b, want d=%h v=%b re=%b we=%b",
                 i, r_data, r_valid, r_err, w_err, e.data, e.valid, e.rerr, e.werr);
      end
    end
  endtask

  task automatic test_forward();
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       apply(1'b1, 4, 1, lanes(30, 1), 1'b0, 0, 0, 1'b0, 0, 1'b0);
        1:       apply(1'b1, 4, 0, lanes(20, 1), 1'b1, 4, 1, 1'b0, 0, 1'b0);
        2:       apply(1'b1, 4, 0, lanes(40, 2), 1'b1, 4, 2, 1'b0, 0, 1'b0);
        default: apply(1'b0, 0, 0, '0, 1'b1, 4, 0, 1'b0, 0, 1'b0);
      endcase
      e = sb.pop_front();
      n_vec++;
      if (r_data !== e.data || r_valid !== e.valid || r_err !== e.rerr || w_err !== e.werr) begin
        n_bad++;
        $display("FAIL forward[%0d]: got d=%h v=%b re=%b we=%b, want d=%h v=%b re=%b we=%b",
                 i, r_data, r_valid, r_err, w_err, e.data, e.valid, e.rerr, e.werr);
      end
    end
  endtask

  task automatic test_clear();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:       apply(1'b1, 2, 0, lanes(1, 1), 1'b0, 0, 0, 1'b0, 0, 1'b0);
        1:       apply(1'b0, 0, 0, '0, 1'b1, 2, 0, 1'b0, 0, 1'b0);
        2:       apply(1'b1, 2, 0, lanes(7, 0), 1'b1, 2, 0, 1'b1, 2, 1'b0);
        3:       apply(1'b0, 0, 0, '0, 1'b1, 2, 0, 1'b0, 0, 1'b0);
        4:       apply(1'b0, 0, 0, '0, 1'b1, 5, 2, 1'b1, 5, 1'b0);
        5:       apply(1'b0, 0, 0, '0, 1'b1, 5, 2, 1'b0, 0, 1'b0);
        6:       apply(1'b1, 3, 1, lanes(50, 1), 1'b1, 1, 0, 1'b1, 4, 1'b0);
        7:       apply(1'b0, 0, 0, '0, 1'b1, 4, 1, 1'b0, 0, 1'b0);
        default: apply(1'b0, 0, 0, '0, 1'b1, 3, 1, 1'b0, 0, 1'b0);
      endcase
      e = sb.pop_front();
      n_vec++;
      if (r_data !== e.data || r_valid !== e.valid || r_err !== e.rerr || w_err !== e.werr) begin
        n_bad++;
        $display("FAIL clear[%0d]: got d=%h v=%b re=%b we=%b, want d=%h v=%b re=%b we=%b",
                 i, r_data, r_valid, r_err, w_err, e.data, e.valid, e.rerr, e.werr);
      end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0:       apply(1'b0, 0, 0, '0, 1'b1, 6, 0, 1'b0, 0, 1'b0);
        1:       apply(1'b0, 0, 0, '0, 1'b1, 3, 2, 1'b0, 0, 1'b0);
        2:       apply(1'b1, 0, 0, lanes(60, 0), 1'b0, 0, 0, 1'b0, 0, 1'b0);
        3:       apply(1'b1, 2, 1, lanes(61, 0), 1'b1, 0, 0, 1'b0, 0, 1'b0);
        4:       apply(1'b1, 7, 0, lanes(62, 0), 1'b1, 2, 0, 1'b1, 7, 1'b0);
        5:       apply(1'b0, 0, 0, '0, 1'b1, 2, 0, 1'b1, 0, 1'b0);
        default: apply(1'b0, 0, 0, '0, 1'b1, 1, 1, 1'b0, 0, 1'b0);
      endcase
      e = sb.pop_front();
      n_vec++;
      if (r_data !== e.data || r_valid !== e.valid || r_err !== e.rerr || w_err !== e.werr) begin
        n_bad++;
        $display("FAIL errors[%0d]: got d=%h v=%b re=%b we=%b, want d=%h v=%b re=%b we=%b",
                 i, r_data, r_valid, r_err, w_err, e.data, e.valid, e.rerr, e.werr);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0:       apply(1'b1, 5, 3, lanes(11, 3), 1'b1, 3, 1, 1'b0, 0, 1'b0);
        1:       apply(1'b1, 5, 2, lanes(2, 5), 1'b1, 5, 7, 1'b0, 0, 1'b0);
        2:       apply(1'b1, 1, 0, lanes(33, 1), 1'b1, 5, 6, 1'b0, 0, 1'b1);
        3:       apply(1'b0, 0, 0, '0, 1'b1, 5, 6, 1'b0, 0, 1'b0);
        default: apply(1'b0, 0, 0, '0, 1'b1, 2, 0, 1'b0, 0, 1'b0);
      endcase
      e = sb.pop_front();
      n_vec++;
      if (r_data !== e.data || r_valid !== e.valid || r_err !== e.rerr || w_err !== e.werr) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got d=%h v=%b re=%b we=%b, want d=%h v=%b re=%b we=%b",
                 i, r_data, r_valid, r_err, w_err, e.data, e.valid, e.rerr, e.werr);
      end
    end
  endtask

  initial begin
    rst = 1'b1; w_en = 1'b0; w_layer = '0; w_addr = '0; w_data = '0;
    r_en = 1'b0; r_layer = '0; r_addr = '0; clr_en = 1'b0; clr_layer = '0;
    for (int l = 0; l < 8; l++) for (int x = 0; x < 32; x++) mdl[l][x] = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_forward();
    test_clear();
    test_errors();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
